// File: rtl/apb_slv_decoder.sv
// rtl/apb_slv_decoder.sv - APB fan-out from one master to NUM_SLV slaves with error slave and error counter
// Define APB_TIMEOUT_EN to enable the access-phase watchdog, ABORT state and oTimeout pulse.
module apb_slv_decoder #(
  parameter int                NUM_SLV     = 4,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                SLV_ADDR_W  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h7000_0000,
  parameter int                TIMEOUT_CYC = 255,
  parameter int                TO_CNT_W    = 8
) (
  input  logic                      iClk,
  input  logic                      iRsn,
  input  logic                      iPsel,
  input  logic                      iPenable,
  input  logic                      iPwrite,
  input  logic [ADDR_W-1:0]         iPaddr,
  input  logic [DATA_W-1:0]         iPwdata,
  output logic [DATA_W-1:0]         oPrdata,
  output logic                      oPready,
  output logic                      oPslverr,
  output logic [NUM_SLV-1:0]        oPsel,
  output logic                      oPenable,
  output logic                      oPwrite,
  output logic [SLV_ADDR_W-1:0]     oPaddr,
  output logic [DATA_W-1:0]         oPwdata,
  input  logic [NUM_SLV*DATA_W-1:0] iPrdata,
  input  logic [NUM_SLV-1:0]        iPready,
  input  logic [NUM_SLV-1:0]        iPslverr,
  input  logic                      iErrClr,
  output logic [15:0]               oErrCnt,
  output logic                      oTimeout
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ABORT} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_hit;
  logic [15:0]        r_err_cnt;

  logic [ADDR_W-1:0]  w_off;
  logic [ADDR_W-1:0]  w_idx_full;
  logic               w_hit;
  logic               w_setup;
  logic               w_access;
  logic               w_proto_err;
  logic               w_slv_ready;
  logic               w_timeout;
  logic               w_abort;
  logic               w_ready;
  logic               w_slverr;
  logic [DATA_W-1:0]  w_rdata;

  assign w_off       = iPaddr - BASE_ADDR;
  assign w_idx_full  = w_off >> SLV_ADDR_W;
  assign w_hit       = (iPaddr >= BASE_ADDR) && (w_idx_full < ADDR_W'(NUM_SLV));
  assign w_setup     = iPsel && !iPenable;
  assign w_access    = (r_state == S_ACCESS) && iPenable;
  assign w_proto_err = (r_state == S_IDLE) && iPsel && iPenable;
  assign w_slv_ready = iPready[r_idx];

  always_comb begin
    oPsel = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      oPsel[k] = iPsel && w_hit && !w_abort && (w_idx_full == ADDR_W'(k));
    end
  end

  assign oPenable = iPenable && (r_state == S_ACCESS) && !w_abort;
  assign oPwrite  = iPwrite;
  assign oPaddr   = iPaddr[SLV_ADDR_W-1:0];
  assign oPwdata  = iPwdata;

`ifdef APB_TIMEOUT_EN
  logic [TO_CNT_W-1:0] r_cnt;
  logic                r_abort;

  // A slave PREADY in the last allowed cycle wins over the watchdog.
  assign w_timeout = w_access && r_hit && !w_slv_ready &&
                     (r_cnt == TO_CNT_W'(TIMEOUT_CYC - 1));
  assign w_abort   = r_abort;

  always_ff @(posedge iClk) begin
    if (iRsn) begin
      r_cnt   <= '0;
      r_abort <= 1'b0;
    end else begin
      r_abort <= (w_next == S_ABORT);
      if ((r_state == S_IDLE) && w_setup)
        r_cnt <= '0;
      else if ((r_state == S_ACCESS) && r_hit && !w_slv_ready)
        r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{TIMEOUT_CYC, TO_CNT_W};
  assign w_timeout    = 1'b0;
  assign w_abort      = 1'b0;
`endif

  always_comb begin
    w_ready  = 1'b0;
    w_slverr = 1'b0;
    w_rdata  = '0;
    if (!iRsn) begin
      if (w_access) begin
        if (!r_hit) begin
          w_ready  = 1'b1;
          w_slverr = 1'b1;
        end else if (w_timeout) begin
          w_ready  = 1'b1;
          w_slverr = 1'b1;
        end else begin
          w_ready  = w_slv_ready;
          w_slverr = iPslverr[r_idx] && w_slv_ready;
          w_rdata  = iPrdata[r_idx*DATA_W +: DATA_W];
        end
      end else if (w_proto_err) begin
        w_ready  = 1'b1;
        w_slverr = 1'b1;
      end
    end
  end

  assign oPready  = w_ready;
  assign oPslverr = w_slverr;
  assign oPrdata  = w_rdata;
  assign oTimeout = w_timeout && !iRsn;
  assign oErrCnt  = r_err_cnt;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_setup) w_next = S_ACCESS;
      S_ACCESS: if (w_ready) w_next = w_timeout ? S_ABORT : S_IDLE;
      S_ABORT:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRsn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && w_setup) begin
        r_idx <= w_idx_full[IDX_W-1:0];
        r_hit <= w_hit;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRsn || iErrClr)
      r_err_cnt <= '0;
    else if (w_ready && w_slverr && (r_err_cnt != 16'hFFFF))
      r_err_cnt <= r_err_cnt + 16'd1;
  end

endmodule

// File: doc/apb_slv_decoder.md
Name: apb_slv_decoder

Overview:
- Parametrised APB fan-out stage between the Axi2Apb APB master port and NUM_SLV APB slaves. Generalises the fixed 4-slave PSEL/PRDATA/PREADY mux.
- Decodes the full master address into a one-hot slave select and muxes the response. Adds PSLVERR, a default error slave for unmapped addresses, a per-transfer timeout watchdog and a saturating error counter.

Parameters:
- NUM_SLV, 4, number of slave ports (1..16)
- ADDR_W, 32, master address width
- DATA_W, 32, data width
- SLV_ADDR_W, 16, address bits forwarded to slaves (= log2 of window size)
- BASE_ADDR, 32'h7000_0000, base of slave 0 window; slave k at BASE_ADDR + k<<SLV_ADDR_W
- TIMEOUT_CYC, 255, max access-phase cycles before forced error (>=2)
- TO_CNT_W, 8, timeout counter width, must hold TIMEOUT_CYC

Ports:
- iClk  in  1  clock
- iRsn  in  1  synchronous, active-high reset (1 = reset)
- iPsel  in  1  master PSEL
- iPenable  in  1  master PENABLE
- iPwrite  in  1  master PWRITE
- iPaddr  in  ADDR_W  master PADDR
- iPwdata  in  DATA_W  master PWDATA
- oPrdata  out  DATA_W  response data to master
- oPready  out  1  response ready to master
- oPslverr  out  1  response error to master
- oPsel  out  NUM_SLV  one-hot slave select
- oPenable  out  1  PENABLE to slaves
- oPwrite  out  1  PWRITE to slaves
- oPaddr  out  SLV_ADDR_W  iPaddr[SLV_ADDR_W-1:0]
- oPwdata  out  DATA_W  PWDATA to slaves
- iPrdata  in  NUM_SLV*DATA_W  packed slave read data, slave k at [k*DATA_W +: DATA_W]
- iPready  in  NUM_SLV  slave PREADY
- iPslverr  in  NUM_SLV  slave PSLVERR
- iErrClr  in  1  clears oErrCnt
- oErrCnt  out  16  saturating count of error responses
- oTimeout  out  1  one-cycle pulse on timeout abort

Behaviour:
- Decode (combinational):
  - off = iPaddr - BASE_ADDR; idx = off >> SLV_ADDR_W.
  - hit = (iPaddr >= BASE_ADDR) && (idx < NUM_SLV).
- Slave-side outputs:
  - oPsel[idx] = iPsel & hit & ~rAbort; all other bits 0. oPsel = 0 when miss.
  - oPenable = iPenable & (state==ACCESS) & ~rAbort.
  - oPwrite, oPaddr, oPwdata are pass-through.
- FSM states: IDLE, ACCESS, ABORT.
  - IDLE: when iPsel & ~iPenable (setup), latch rIdx<=idx, rHit<=hit, counter<=0, then go to ACCESS.
  - ACCESS: the transfer completes when oPready=1. On completion, go to IDLE. If the same cycle is also a new setup (not legal APB), ignore it.
  - ABORT: entered only from a timeout. Lasts 1 cycle. Slave oPsel/oPenable are forced 0. Then go to IDLE.
- Response muxing (combinational, zero added latency) in ACCESS with iPenable=1:
  - rHit=1: oPrdata=iPrdata[rIdx], oPready=iPready[rIdx], oPslverr=iPslverr[rIdx]&iPready[rIdx].
  - rHit=0: default slave. oPready=1 on the first access cycle, oPslverr=1, oPrdata=0.
- Outside ACCESS: oPready=0, oPslverr=0, oPrdata=0.
- Protocol error: iPsel & iPenable while in IDLE (no setup seen). Respond as the default slave (oPready=1, oPslverr=1) in the same cycle. oPsel stays 0. Counts as an error.
- Timeout (APB_TIMEOUT_EN only):
  - Counter increments each ACCESS cycle with rHit & ~iPready[rIdx].
  - When counter==TIMEOUT_CYC-1 and ready is still low: oPready=1, oPslverr=1, oPrdata=0 and oTimeout=1 for that cycle. rAbort<=1 and the FSM goes to ABORT.
  - A slave PREADY arriving in that same cycle wins: normal completion, no timeout.
- Error counter:
  - Increments by 1 on every completed transfer with oPslverr=1. Saturates at 16'hFFFF.
  - iErrClr has priority over a simultaneous increment (result 0).
- Reset (iRsn=1, synchronous): state=IDLE, rIdx=0, rHit=0, rAbort=0, counter=0, oErrCnt=0, oTimeout=0.
  - Mid-transfer reset abandons the transfer; no oPready is issued.
  - During reset, oPready/oPslverr/oPrdata are held 0. oPsel still follows the combinational decode.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: watchdog, ABORT state and oTimeout are active as described.
- Undefined: no counter or ABORT logic; access waits indefinitely for PREADY; oTimeout is tied to 0. TIMEOUT_CYC and TO_CNT_W are unused.

Test Plan:
- Write 0x7002_0010 data 0xA5A5_5A5A; slave 2 inserts 2 wait states -> oPsel=4'b0100, oPaddr=16'h0010, oPready=1 on the 3rd access cycle, oPslverr=0, oErrCnt unchanged.
- Read 0x7003_0004; slave 3 returns 0xDEAD_BEEF with zero waits -> oPrdata=0xDEAD_BEEF, oPready=1 on the first access cycle.
- Read 0x7004_0000 (unmapped) and 0x6FFF_FFFC -> oPsel=0, oPready=1 and oPslverr=1 on the first access cycle, oPrdata=0, oErrCnt 0->2.
- With APB_TIMEOUT_EN and TIMEOUT_CYC=255: slave 1 holds PREADY=0 -> oPready=1/oPslverr=1 and a one-cycle oTimeout on the 255th access cycle, then oPsel[1]=0 for 1 cycle, oErrCnt+1. A second run with slave PREADY=1 on cycle 255 -> normal completion, no timeout.
- Slave 0 returns PSLVERR=1 with oErrCnt=16'hFFFF -> oErrCnt stays 16'hFFFF. Assert iErrClr in the same cycle as an error -> oErrCnt=0.
- Assert iRsn=1 during an ACCESS wait on slave 2 -> next cycle state=IDLE, oErrCnt=0, no oPready. A following transfer to 0x7000_0000 completes normally.
